// File: rtl/cycle_incr_scheduler_pkg.sv
// Shared types and default sizes for the round-robin increment scheduler.
package cycle_sched_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/cycle_incr_scheduler_if.sv
// Requester-side and response-side handshake bundle of the increment scheduler.
interface cycle_sched_if
  import cycle_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W
);
  localparam int ID_W = $clog2(NUM_REQ);

  // A transfer happens only on a cycle where valid and ready are both high;
  // the source holds data stable while valid is high and ready is low.
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic [ID_W-1:0]           rsp_id;
  logic                      rsp_wrap;
  logic                      rsp_ready;
  logic                      busy;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_wrap, busy
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_wrap, busy
  );

endinterface

// File: rtl/cycle_incr_scheduler_incr_stage.sv
// Registered increment stage: captures din+1 (modulo 2^DATA_W) and an all-ones flag.
module incr_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              wrap
);

  logic [DATA_W-1:0] dout_q, dout_d;
  logic              wrap_q, wrap_d;

  always_comb begin
    dout_d = dout_q;
    wrap_d = wrap_q;
    if (load_en) begin
      dout_d = din + DATA_W'(1);
      wrap_d = &din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      wrap_q <= wrap_d;
    end
  end

  assign dout = dout_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/cycle_incr_scheduler.sv
// Round-robin scheduler granting one requester at a time to a shared
// increment stage; one result per grant, returned with the requester index.
module cycle_incr_scheduler
  import cycle_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic            clk,
  input  logic            reset,
  cycle_sched_if.slave    sif,
  output state_t          dbg_state,
  output logic [ID_W-1:0] dbg_rr_ptr
);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] op_q, op_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  int                scan_idx;
  logic [NUM_REQ-1:0] req_ready_c;
  logic              load_en;
  logic [DATA_W-1:0] incr_out;
  logic              incr_wrap;

  // First valid requester at or after rr_ptr, wrapping past the top index.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      scan_idx = int'(rr_ptr_q) + off;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!grant_found && sif.req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(scan_idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    op_d        = op_q;
    req_ready_c = '0;
    load_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready_c[grant_idx] = 1'b1;
          op_d    = sif.req_data[grant_idx*DATA_W +: DATA_W];
          id_d    = grant_idx;
          state_d = EXEC;
        end
      end
      EXEC: begin
        load_en = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (sif.rsp_ready) begin
          state_d  = IDLE;
          rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      op_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      op_q     <= op_d;
    end
  end

  incr_stage #(.DATA_W(DATA_W)) u_incr (
    .clk     (clk),
    .reset   (reset),
    .load_en (load_en),
    .din     (op_q),
    .dout    (incr_out),
    .wrap    (incr_wrap)
  );

  // The grant strobe is combinational, so it is masked while reset is asserted.
  assign sif.req_ready = reset ? '0 : req_ready_c;
  assign sif.rsp_valid = (state_q == RESP);
  assign sif.rsp_data  = incr_out;
  assign sif.rsp_id    = id_q;
  assign sif.rsp_wrap  = incr_wrap;
  assign sif.busy      = (state_q != IDLE);

  assign dbg_state  = state_q;
  assign dbg_rr_ptr = rr_ptr_q;

endmodule
